// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC sample post-processing path.
// Holds the code/BCD widths, the blank nibble, FSM states and code extraction.
package adc_pkg;

  localparam int CODE_W = 8;
  localparam int BIN_W  = 14;
  localparam int BCD_W  = 16;

  localparam logic [3:0] BLANK_DEF = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCALE,
    ST_CONV,
    ST_FORMAT
  } state_e;

  // The 8-bit sample code sits in bits [11:4] of the IIC read word.
  function automatic logic [CODE_W-1:0] get_code(
    input logic [15:0] word
  );
    return {word[11:8], word[7:4]};
  endfunction

endpackage

// File: rtl/adc_sample_proc_bin2bcd.sv
// Sequential 14-bit double-dabble: start loads, one bit per clock, 14 clocks.
// Ports: adc_clk, adc_rst, start, bin_in -> busy, done (last iteration), bcd_out.
module bin2bcd_seq
  import adc_pkg::*;
(
  input  logic             adc_clk,
  input  logic             adc_rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd_out
);

  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [3:0]       cnt_q;
  logic [BCD_W-1:0] bcd_adj;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge adc_clk or negedge adc_rst) begin
    if (!adc_rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      bin_q <= bin_in;
      bcd_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
      cnt_q <= cnt_q + 4'd1;
      if (cnt_q == 4'(BIN_W - 1))
        busy <= 1'b0;
    end
  end

  // High during the final shift so the caller can leave CONV on that edge.
  assign done    = busy & (cnt_q == 4'(BIN_W - 1));
  assign bcd_out = bcd_q;

endmodule

// File: rtl/adc_sample_proc.sv
// ADC sample post-processing: sliding average, optional mV scale, BCD display.
// Ports: sample_in/sample_valid/mode in; avg_code, busy, dsp_data, dsp_valid out.
module adc_sample_proc
  import adc_pkg::*;
#(
  parameter int         AVG_SHIFT  = 3,
  parameter int         VREF_MV    = 3300,
  parameter logic [3:0] BLANK_CODE = BLANK_DEF
) (
  input  logic              adc_clk,
  input  logic              adc_rst,
  input  logic [15:0]       sample_in,
  input  logic              sample_valid,
  input  logic              mode,
  output logic [CODE_W-1:0] avg_code,
  output logic              busy,
  output logic [31:0]       dsp_data,
  output logic              dsp_valid
);

  localparam int DEPTH  = 1 << AVG_SHIFT;
  localparam int SUM_W  = CODE_W + AVG_SHIFT;
  localparam int PTR_W  = (AVG_SHIFT > 0) ? AVG_SHIFT : 1;
  localparam int PROD_W = CODE_W + 14;

  logic [CODE_W-1:0] win_q [DEPTH];
  logic [SUM_W-1:0]  sum_q;
  logic [SUM_W-1:0]  sum_nxt;
  logic [PTR_W-1:0]  wp_q;
  logic              primed_q;
  logic [CODE_W-1:0] code;

  assign code    = get_code(sample_in);
  assign sum_nxt = sum_q + SUM_W'(code) - SUM_W'(win_q[wp_q]);

  always_ff @(posedge adc_clk or negedge adc_rst) begin
    if (!adc_rst) begin
      for (int i = 0; i < DEPTH; i++)
        win_q[i] <= '0;
      sum_q    <= '0;
      wp_q     <= '0;
      primed_q <= 1'b0;
      avg_code <= '0;
    end else if (sample_valid) begin
      if (!primed_q) begin
        // Fill the whole window so the first average is the sample itself.
        for (int i = 0; i < DEPTH; i++)
          win_q[i] <= code;
        sum_q    <= SUM_W'(code) << AVG_SHIFT;
        primed_q <= 1'b1;
        avg_code <= code;
      end else begin
        win_q[wp_q] <= code;
        sum_q       <= sum_nxt;
        wp_q        <= (wp_q == PTR_W'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
        avg_code    <= sum_nxt[SUM_W-1:AVG_SHIFT];
      end
    end
  end

  logic [PROD_W-1:0] prod;
  logic [BIN_W-1:0]  scaled;

  assign prod   = PROD_W'(avg_code) * PROD_W'(VREF_MV);
  assign scaled = mode ? prod[BIN_W+7:8] : BIN_W'(avg_code);

  state_e            state_q;
  logic              pending_q;
  logic              conv_start;
  logic              conv_busy;
  logic              conv_done;
  logic [BCD_W-1:0]  bcd;

  // Start is combinational so the converter loads on the SCALE edge.
  assign conv_start = (state_q == ST_SCALE);

  bin2bcd_seq u_bcd (
    .adc_clk (adc_clk),
    .adc_rst (adc_rst),
    .start   (conv_start),
    .bin_in  (scaled),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd_out (bcd)
  );

  logic [31:0] disp;
  logic        lead;

  always_comb begin
    disp = {8{BLANK_CODE}};
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (bcd[4*i +: 4] != 4'd0)
        lead = 1'b0;
      if (!lead)
        disp[4*i +: 4] = bcd[4*i +: 4];
    end
    disp[3:0] = bcd[3:0];
  end

  always_ff @(posedge adc_clk or negedge adc_rst) begin
    if (!adc_rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      dsp_data  <= {8{BLANK_CODE}};
      dsp_valid <= 1'b0;
    end else begin
      dsp_valid <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (sample_valid)
            state_q <= ST_SCALE;
        end
        ST_SCALE: begin
          if (sample_valid)
            pending_q <= 1'b1;
          state_q <= ST_CONV;
        end
        ST_CONV: begin
          if (sample_valid)
            pending_q <= 1'b1;
          if (conv_done)
            state_q <= ST_FORMAT;
        end
        ST_FORMAT: begin
          dsp_data  <= disp;
          dsp_valid <= 1'b1;
          pending_q <= 1'b0;
          // A sample landing on this edge still needs its own conversion.
          state_q   <= (pending_q | sample_valid) ? ST_SCALE : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = conv_busy
              | (state_q == ST_SCALE)
              | (state_q == ST_FORMAT);

endmodule

// File: tb/tb_adc_sample_proc.sv
// Bench for adc_sample_proc: queue-based window model plus conversion timeline.
// Directed literal cases pin the model; random traffic is checked every cycle.
module tb_adc_sample_proc;

  localparam int AVG_SHIFT = 3;
  localparam int VREF_MV   = 3300;
  localparam int DEPTH     = 1 << AVG_SHIFT;
  localparam int LAT       = 16;

  logic        adc_clk = 1'b0;
  logic        adc_rst = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  avg_code;
  logic        busy;
  logic [31:0] dsp_data;
  logic        dsp_valid;

  adc_sample_proc #(
    .AVG_SHIFT  (AVG_SHIFT),
    .VREF_MV    (VREF_MV),
    .BLANK_CODE (4'd10)
  ) dut (
    .adc_clk      (adc_clk),
    .adc_rst      (adc_rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .mode         (mode),
    .avg_code     (avg_code),
    .busy         (busy),
    .dsp_data     (dsp_data),
    .dsp_valid    (dsp_valid)
  );

  always #5 adc_clk = ~adc_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt(input int v);
    logic [31:0] r;
    r = 32'hAAAAAAAA;
    r[3:0] = 4'(v % 10);
    if (v >= 10)   r[7:4]   = 4'((v / 10) % 10);
    if (v >= 100)  r[11:8]  = 4'((v / 100) % 10);
    if (v >= 1000) r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  // Model: window = last DEPTH codes; a conversion spans 16 edges from its
  // start, snapshots the average one edge in, and any sample arriving while
  // one is in flight asks for exactly one more conversion.
  int          m_win[$];
  bit          m_primed = 0;
  int          m_avg = 0;
  bit          m_active = 0;
  int          m_age = 0;
  bit          m_pend = 0;
  int          m_val = 0;
  logic [31:0] m_data = 32'hAAAAAAAA;
  bit          m_vld = 0;

  always @(posedge adc_clk) begin
    if (!adc_rst) begin
      m_win.delete();
      m_primed = 0;
      m_avg    = 0;
      m_active = 0;
      m_age    = 0;
      m_pend   = 0;
      m_data   = 32'hAAAAAAAA;
      m_vld    = 0;
    end else begin
      int c;
      int s;
      m_vld = 0;
      if (m_active) begin
        m_age++;
        if (m_age == 1)
          m_val = mode ? ((m_avg * VREF_MV) >> 8) % 16384 : m_avg;
        if (m_age == LAT) begin
          m_vld  = 1;
          m_data = fmt(m_val);
          if (m_pend || sample_valid) begin
            m_age  = 0;
            m_pend = 0;
          end else begin
            m_active = 0;
          end
        end else if (sample_valid) begin
          m_pend = 1;
        end
      end else if (sample_valid) begin
        m_active = 1;
        m_age    = 0;
      end
      if (sample_valid) begin
        c = int'(sample_in[11:4]);
        if (!m_primed) begin
          m_win.delete();
          repeat (DEPTH) m_win.push_back(c);
          m_primed = 1;
        end else begin
          m_win.push_back(c);
          void'(m_win.pop_front());
        end
        s = 0;
        foreach (m_win[i]) s += m_win[i];
        m_avg = s / DEPTH;
      end
    end
  end

  always @(negedge adc_clk) begin
    chk("avg_code",  avg_code,  m_avg);
    chk("busy",      busy,      m_active);
    chk("dsp_valid", dsp_valid, m_vld);
    chk("dsp_data",  dsp_data,  m_data);
  end

  task automatic send(input logic [15:0] w, input logic md);
    sample_in    = w;
    mode         = md;
    sample_valid = 1'b1;
    @(negedge adc_clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int lat,
                            input logic [31:0] exp);
    int n;
    n = 0;
    do begin
      @(negedge adc_clk);
      n++;
    end while (!dsp_valid && n < 40);
    if (lat > 0)
      chk({name, "_lat"}, n, lat);
    chk({name, "_dsp"}, dsp_data, exp);
    chk({name, "_mdl"}, m_data, exp);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge adc_clk);
      n++;
    end while (busy && n < 80);
    chk({name, "_idle"}, busy, 1'b0);
    #1;
  endtask

  task automatic do_reset();
    adc_rst = 1'b0;
    repeat (2) @(negedge adc_clk);
    #1;
    adc_rst = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge adc_clk);
    chk("rst_dsp",   dsp_data,  32'hAAAAAAAA);
    chk("rst_valid", dsp_valid, 1'b0);
    chk("rst_busy",  busy,      1'b0);
    chk("rst_avg",   avg_code,  8'd0);
    #1;
    adc_rst = 1'b1;
    repeat (20) @(negedge adc_clk);
    #1;

    send(16'h0800, 1'b0);
    chk("t1_avg", avg_code, 8'd128);
    chk("t1_busy", busy, 1'b1);
    wait_valid("t1", LAT, 32'hAAAAA128);

    do_reset();
    send(16'h0FF0, 1'b1);
    wait_valid("t2", LAT, 32'hAAAA3287);

    do_reset();
    send(16'h0000, 1'b0);
    wait_valid("t3a", LAT, 32'hAAAAAAA0);
    send(16'h0080, 1'b0);
    chk("t3b_avg", avg_code, 8'd1);
    wait_valid("t3b", LAT, 32'hAAAAAAA1);
    repeat (7) send(16'h0080, 1'b0);
    chk("t3c_avg", avg_code, 8'd8);
    wait_idle("t3c");
    chk("t3c_dsp", dsp_data, 32'hAAAAAAA8);

    do_reset();
    send(16'h0640, 1'b0);
    repeat (4) @(negedge adc_clk);
    #1;
    send(16'h0C80, 1'b0);
    chk("t4_avg", avg_code, 8'd112);
    wait_valid("t4a", 0, 32'hAAAAA100);
    wait_valid("t4b", LAT, 32'hAAAAA112);
    wait_idle("t4");

    send(16'h0FF0, 1'b0);
    repeat (6) @(negedge adc_clk);
    chk("t5_busy_pre", busy, 1'b1);
    #1;
    adc_rst = 1'b0;
    #1;
    chk("t5_dsp",   dsp_data,  32'hAAAAAAAA);
    chk("t5_busy",  busy,      1'b0);
    chk("t5_valid", dsp_valid, 1'b0);
    chk("t5_avg",   avg_code,  8'd0);
    repeat (2) @(negedge adc_clk);
    #1;
    adc_rst = 1'b1;
    repeat (25) @(negedge adc_clk);
    #1;
    send(16'h0320, 1'b0);
    chk("t5_reprime", avg_code, 8'd50);
    wait_valid("t5", LAT, 32'hAAAAAA50);

    for (int i = 0; i < 600; i++) begin
      sample_in    = 16'($urandom);
      mode         = 1'($urandom);
      sample_valid = ($urandom_range(0, 5) == 0);
      @(negedge adc_clk);
      #1;
    end
    sample_valid = 1'b0;
    repeat (40) @(negedge adc_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
